// File: rtl/sid_env_bank_if.sv
// Control and register-write bus for the SID-style envelope bank.
// The address carries {voice index, register select}.
interface sid_env_bank_if #(
    parameter int NUM_VOICES = 3
);
    localparam int VA_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic            ena;
    logic            tick;
    logic            wr_en;
    logic [VA_W+1:0] wr_addr;
    logic [7:0]      wr_data;

    modport master (output ena, output tick, output wr_en, output wr_addr, output wr_data);
    modport slave  (input  ena, input  tick, input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/sid_env_bank.sv
// Bank of independent ADSR envelope generators with per-voice prescalers
// and a registered sum of all envelope levels.
module sid_env_bank #(
    parameter int NUM_VOICES = 3,
    parameter int ENV_W      = 8,
    parameter int RATE_SHIFT = 0,
    localparam int VA_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int MIX_W     = ENV_W + $clog2(NUM_VOICES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sid_env_bank_if.slave               bus,
    output logic [NUM_VOICES*ENV_W-1:0] env_out,
    output logic [NUM_VOICES-1:0]       active,
    output logic [MIX_W-1:0]            mix_out
);
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    localparam int PW = 5 + RATE_SHIFT;
    localparam logic [ENV_W-1:0] LEVEL_MAX = '1;

    state_t           state     [NUM_VOICES];
    logic [ENV_W-1:0] level     [NUM_VOICES];
    logic [PW-1:0]    presc     [NUM_VOICES];
    logic [3:0]       atk_rate  [NUM_VOICES];
    logic [3:0]       dec_rate  [NUM_VOICES];
    logic [3:0]       sus_val   [NUM_VOICES];
    logic [3:0]       rel_rate  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate;
    logic [NUM_VOICES-1:0] gate_prev;
    logic [MIX_W-1:0]      level_sum;
    logic                  step_tick;

    // Prescaler terminal count: period is (rate+1) << RATE_SHIFT ticks.
    function automatic logic [PW-1:0] last_count(input logic [3:0] rate);
        return ((PW'(rate) + PW'(1)) << RATE_SHIFT) - PW'(1);
    endfunction

    assign step_tick = bus.ena && bus.tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                atk_rate[v] <= '0;
                dec_rate[v] <= '0;
                sus_val[v]  <= '0;
                rel_rate[v] <= '0;
            end
        end else if (bus.wr_en) begin
            // Voice indices past NUM_VOICES never match, so those writes drop out.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (bus.wr_addr[VA_W+1:2] == VA_W'(v)) begin
                    case (bus.wr_addr[1:0])
                        2'd0: {atk_rate[v], dec_rate[v]} <= bus.wr_data;
                        2'd1: {sus_val[v], rel_rate[v]}  <= bus.wr_data;
                        2'd2: gate[v] <= bus.wr_data[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_prev <= '0;
            active    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                state[v] <= IDLE;
                level[v] <= '0;
                presc[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                gate_prev[v] <= gate[v];
                // An acting gate edge wins over any step due on the same clock.
                if (gate[v] && !gate_prev[v] && (state[v] == IDLE || state[v] == RELEASE)) begin
                    state[v]  <= ATTACK;
                    presc[v]  <= '0;
                    active[v] <= 1'b1;
                end else if (!gate[v] && gate_prev[v] &&
                             (state[v] == ATTACK || state[v] == DECAY || state[v] == SUSTAIN)) begin
                    state[v] <= RELEASE;
                    presc[v] <= '0;
                end else begin
                    case (state[v])
                        ATTACK: begin
                            if (step_tick) begin
                                if (presc[v] == last_count(atk_rate[v])) begin
                                    presc[v] <= '0;
                                    if (level[v] != LEVEL_MAX)
                                        level[v] <= level[v] + ENV_W'(1);
                                    if (level[v] >= LEVEL_MAX - ENV_W'(1))
                                        state[v] <= DECAY;
                                end else begin
                                    presc[v] <= presc[v] + PW'(1);
                                end
                            end
                        end
                        DECAY: begin
                            if (level[v] <= (ENV_W'(sus_val[v]) << (ENV_W - 4))) begin
                                state[v] <= SUSTAIN;
                                presc[v] <= '0;
                            end else if (step_tick) begin
                                if (presc[v] == last_count(dec_rate[v])) begin
                                    presc[v] <= '0;
                                    level[v] <= level[v] - ENV_W'(1);
                                end else begin
                                    presc[v] <= presc[v] + PW'(1);
                                end
                            end
                        end
                        RELEASE: begin
                            if (step_tick) begin
                                if (presc[v] == last_count(rel_rate[v])) begin
                                    presc[v] <= '0;
                                    if (level[v] != '0)
                                        level[v] <= level[v] - ENV_W'(1);
                                    if (level[v] <= ENV_W'(1)) begin
                                        state[v]  <= IDLE;
                                        active[v] <= 1'b0;
                                    end
                                end else begin
                                    presc[v] <= presc[v] + PW'(1);
                                end
                            end
                        end
                        default: presc[v] <= '0;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_env
        assign env_out[g*ENV_W +: ENV_W] = level[g];
    end

    always_comb begin
        level_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            level_sum = level_sum + MIX_W'(level[v]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mix_out <= '0;
        else
            mix_out <= level_sum;
    end
endmodule

// File: tb/tb_sid_env_bank.sv
// Scoreboard bench for sid_env_bank: expectations are queued with each
// stimulus step and drained against the outputs one cycle phase later.
module tb_sid_env_bank;
    localparam int NV    = 3;
    localparam int EW    = 8;
    localparam int MIX_W = EW + $clog2(NV + 1);

    localparam int SEL_ENV    = 0;
    localparam int SEL_ACT    = 1;
    localparam int SEL_MIX    = 2;
    localparam int SEL_ACTV   = 3;
    localparam int SEL_ENVALL = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NV*EW-1:0]  env_out;
    logic [NV-1:0]     active;
    logic [MIX_W-1:0]  mix_out;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string tag;
        int    sel;
        int    idx;
        int    exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sid_env_bank_if #(.NUM_VOICES(NV)) bus ();

    sid_env_bank #(
        .NUM_VOICES(NV),
        .ENV_W     (EW),
        .RATE_SHIFT(0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .env_out(env_out),
        .active (active),
        .mix_out(mix_out)
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int observe(input int sel, input int idx);
        case (sel)
            SEL_ENV:    return int'(env_out[idx*EW +: EW]);
            SEL_ACT:    return int'(active[idx]);
            SEL_MIX:    return int'(mix_out);
            SEL_ACTV:   return int'(active);
            default:    return int'(env_out);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input int idx, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.idx = idx;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain_scoreboard();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, observe(e.sel, e.idx), e.exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] voice, input logic [1:0] rsel, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = {voice, rsel};
        bus.wr_data = data;
        step_clk(1);
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.ena     = 1'b1;
        bus.tick    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        step_clk(2);
        expect_val("reset_env", SEL_ENVALL, 0, 0);
        expect_val("reset_active", SEL_ACTV, 0, 0);
        expect_val("reset_mix", SEL_MIX, 0, 0);
        drain_scoreboard();
        rst_n = 1'b1;
        step_clk(1);

        // Gate write to a nonexistent voice must not start anything.
        applyStimulus(2'd3, 2'd2, 8'h01);
        step_clk(2);
        expect_val("bad_voice_active", SEL_ACTV, 0, 0);
        drain_scoreboard();

        // Voice 0: fastest attack up to full scale, decay to sustain 0x80.
        applyStimulus(2'd0, 2'd0, 8'h00);
        applyStimulus(2'd0, 2'd1, 8'h80);
        applyStimulus(2'd0, 2'd2, 8'h01);
        bus.tick = 1'b1;
        step_clk(1);
        expect_val("atk_start_env", SEL_ENV, 0, 0);
        expect_val("atk_start_active", SEL_ACT, 0, 1);
        drain_scoreboard();
        step_clk(1);
        expect_val("atk_first_env", SEL_ENV, 0, 1);
        expect_val("atk_first_mix", SEL_MIX, 0, 0);
        drain_scoreboard();
        step_clk(253);
        expect_val("atk_254_env", SEL_ENV, 0, 254);
        expect_val("atk_254_mix_lag", SEL_MIX, 0, 253);
        drain_scoreboard();
        step_clk(1);
        expect_val("atk_peak_env", SEL_ENV, 0, 255);
        drain_scoreboard();
        step_clk(127);
        expect_val("decay_env", SEL_ENV, 0, 128);
        drain_scoreboard();
        step_clk(21);
        expect_val("sustain_hold_env", SEL_ENV, 0, 128);
        expect_val("sustain_active", SEL_ACT, 0, 1);
        drain_scoreboard();
        bus.tick = 1'b0;

        // Voice 2 to full scale with a slow decay, then freeze ticks for the mix check.
        applyStimulus(2'd2, 2'd0, 8'h0F);
        applyStimulus(2'd2, 2'd1, 8'h00);
        applyStimulus(2'd2, 2'd2, 8'h01);
        step_clk(1);
        bus.tick = 1'b1;
        step_clk(255);
        bus.tick = 1'b0;
        step_clk(1);
        expect_val("mix_v2_env", SEL_ENV, 2, 255);
        expect_val("mix_v0_env", SEL_ENV, 0, 128);
        expect_val("mix_v1_env", SEL_ENV, 1, 0);
        expect_val("mix_sum", SEL_MIX, 0, 383);
        drain_scoreboard();

        // Voice 2: release down to 0x40, then retrigger.
        applyStimulus(2'd2, 2'd2, 8'h00);
        step_clk(1);
        bus.tick = 1'b1;
        step_clk(191);
        bus.tick = 1'b0;
        expect_val("rel_0x40_env", SEL_ENV, 2, 8'h40);
        expect_val("rel_0x40_active", SEL_ACT, 2, 1);
        drain_scoreboard();
        applyStimulus(2'd2, 2'd2, 8'h01);
        step_clk(1);
        expect_val("retrig_env", SEL_ENV, 2, 8'h40);
        drain_scoreboard();
        bus.tick = 1'b1;
        step_clk(1);
        bus.tick = 1'b0;
        expect_val("retrig_step_env", SEL_ENV, 2, 8'h41);
        drain_scoreboard();

        // Voice 0: release rate 1 from sustain 0x80.
        applyStimulus(2'd0, 2'd1, 8'h81);
        applyStimulus(2'd0, 2'd2, 8'h00);
        step_clk(1);
        bus.tick = 1'b1;
        step_clk(2);
        expect_val("rel_first_env", SEL_ENV, 0, 127);
        drain_scoreboard();
        step_clk(253);
        expect_val("rel_last_env", SEL_ENV, 0, 1);
        expect_val("rel_last_active", SEL_ACT, 0, 1);
        drain_scoreboard();
        step_clk(1);
        expect_val("rel_zero_env", SEL_ENV, 0, 0);
        expect_val("rel_zero_active", SEL_ACT, 0, 0);
        drain_scoreboard();
        bus.tick = 1'b0;

        // Voice 1: attack rate 3 with an enable gap in the middle of a period.
        applyStimulus(2'd1, 2'd0, 8'h30);
        applyStimulus(2'd1, 2'd2, 8'h01);
        step_clk(1);
        bus.tick = 1'b1;
        step_clk(3);
        expect_val("slow_atk_pre_env", SEL_ENV, 1, 0);
        drain_scoreboard();
        step_clk(1);
        expect_val("slow_atk_step_env", SEL_ENV, 1, 1);
        drain_scoreboard();
        step_clk(2);
        bus.ena = 1'b0;
        step_clk(10);
        expect_val("ena_frozen_env", SEL_ENV, 1, 1);
        drain_scoreboard();
        bus.ena = 1'b1;
        step_clk(1);
        expect_val("ena_resume_env", SEL_ENV, 1, 1);
        drain_scoreboard();
        step_clk(1);
        expect_val("ena_resume_step_env", SEL_ENV, 1, 2);
        drain_scoreboard();

        // Asynchronous reset mid-attack clears everything without a clock edge.
        rst_n = 1'b0;
        #1;
        expect_val("async_rst_env", SEL_ENVALL, 0, 0);
        expect_val("async_rst_active", SEL_ACTV, 0, 0);
        expect_val("async_rst_mix", SEL_MIX, 0, 0);
        drain_scoreboard();
        step_clk(2);
        rst_n = 1'b1;
        step_clk(20);
        expect_val("post_rst_active", SEL_ACTV, 0, 0);
        expect_val("post_rst_env", SEL_ENVALL, 0, 0);
        drain_scoreboard();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
